// File: rtl/mips_pipe_pkg.sv
// mips_pipe_pkg: shared types and constants for the MIPS pipeline hazard controller
package mips_pipe_pkg;
    typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} hz_state_t;
    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam int CNT_W_DEFAULT = 16;
endpackage

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// sat_counter: counter that increments on inc and sticks at all-ones
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else if (inc && count != '1) count <= count + 1'b1;
    end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller: advance/hold/squash sequencing for the five-stage MIPS pipeline registers
module pipeline_hazard_controller
    import mips_pipe_pkg::*;
#(
    parameter int MAX_WAIT = 255,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rt_e,
    input  logic             memread_e,
    input  logic             branch_taken_d,
    input  logic             mem_busy_m,
    output logic             pc_enable,
    output logic             ifid_enable,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_enable,
    output logic             memwb_enable,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    hz_state_t state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic inInit, loadUse, runGo, branchFlush, stallCycle;
    // RUN and MEM_WAIT decode identically: a busy memory freezes everything, otherwise normal hazard priority
    always_comb begin
        inInit = rst || state == INIT;
        loadUse = memread_e && rt_e != REG_ZERO && (rt_e == rs_d || rt_e == rt_d);
        runGo = !inInit && !mem_busy_m;
        branchFlush = runGo && !loadUse && branch_taken_d;
        pc_enable = runGo && !loadUse;
        ifid_enable = inInit || (runGo && !loadUse);
        ifid_flush = inInit || branchFlush;
        idex_flush = inInit || (runGo && loadUse);
        exmem_enable = inInit || runGo;
        memwb_enable = inInit || runGo;
        stallCycle = !pc_enable;
        nextState = (!inInit && mem_busy_m) ? MEM_WAIT : RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            waitCnt <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state <= nextState;
            if (state != MEM_WAIT) waitCnt <= '0;
            else if (mem_busy_m && !mem_timeout) waitCnt <= waitCnt + 1'b1;
            mem_timeout <= mem_timeout || (state == MEM_WAIT && mem_busy_m && waitCnt == WAIT_LAST);
        end
    end
    sat_counter #(.W(CNT_W)) stallCounter (
        .clk(clk), .rst(rst), .inc(stallCycle), .count(stall_count)
    );
    sat_counter #(.W(CNT_W)) flushCounter (
        .clk(clk), .rst(rst), .inc(branchFlush), .count(flush_count)
    );
endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Sequencing controller for the five-stage MIPS pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register. Each cycle it decides which stages advance, hold or are squashed, from the load-use hazard, taken-branch and data-memory-busy conditions. It also carries a post-reset pipeline-clear sequence, a memory-wait timeout flag and saturating stall/flush performance counters. It sits beside the datapath and drives the `enable`/flush inputs of every pipeline register.

## Interface
- `MAX_WAIT`, default 255: memory-wait cycles tolerated before `mem_timeout` is set.
- `CNT_W`, default 16: width of the performance counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rs_d` in 5: rs field of the instruction in ID.
- `rt_d` in 5: rt field of the instruction in ID.
- `rt_e` in 5: destination (rt) of the instruction in EX.
- `memread_e` in 1: the instruction in EX is a load.
- `branch_taken_d` in 1: a branch or jump resolved taken in ID.
- `mem_busy_m` in 1: data/image memory is not ready in the MEM stage.
- `pc_enable` out 1: the PC register loads.
- `ifid_enable` out 1: the IF/ID register loads.
- `ifid_flush` out 1: the IF/ID register loads a NOP.
- `idex_flush` out 1: the ID/EX register loads a bubble.
- `exmem_enable` out 1: the EX/MEM register loads.
- `memwb_enable` out 1: the MEM/WB register loads.
- `mem_timeout` out 1: sticky error flag.
- `stall_count` out CNT_W: number of stall cycles, saturating.
- `flush_count` out CNT_W: number of branch flushes, saturating.

## Operation
- FSM states: INIT, RUN, MEM_WAIT.
- **INIT**: entered on reset and held for exactly 1 cycle.
  - `pc_enable=0`, `ifid_flush=1`, `idex_flush=1`.
  - `exmem_enable=1`, `memwb_enable=1`.
  - Next state is always RUN.
- **Load-use condition (lu)**: `memread_e && rt_e!=0 && (rt_e==rs_d || rt_e==rt_d)`.
- **RUN** decode, in priority order:
  1. `mem_busy_m`: all enables 0, no flush. Next state is MEM_WAIT.
  2. `lu`: `pc_enable=0`, `ifid_enable=0`, `idex_flush=1`. EX/MEM and MEM/WB advance. `branch_taken_d` is ignored this cycle, because its operands are not yet valid.
  3. `branch_taken_d`: all stages advance, `ifid_flush=1`.
  4. Otherwise all enables are 1 and no flushes are asserted.
- **MEM_WAIT**: freezes the whole pipeline while `mem_busy_m=1`.
  - All enables are 0 and no flush is asserted.
  - `lu` and `branch_taken_d` are ignored.
  - When `mem_busy_m` drops, the same cycle is decoded exactly as in RUN (items 2–4). Next state is RUN.
- **Wait counter**:
  - Cleared on entry to MEM_WAIT.
  - Increments each cycle spent in MEM_WAIT.
  - When the counter reaches `MAX_WAIT` while still busy, `mem_timeout` sets to 1 and stays set until `rst`. The pipeline stays frozen; there is no recovery.
- **`stall_count`**: increments on every cycle with `pc_enable=0`, including INIT, lu and memory-wait cycles. It saturates at all-ones.
- **`flush_count`**: increments on every cycle with a priority-3 branch flush. It saturates at all-ones.
- **Register 0**: a load to $zero never causes a stall.

## Timing
- All control outputs are combinational from the current state and the current inputs, so a hazard is acted on in the same cycle it is presented.
- State, the wait counter, `mem_timeout` and both performance counters update on the rising edge of `clk`.
- Registered outputs are reset to 0.
- The combinational outputs take INIT values during the reset cycle and the cycle after it.
- A load-use stall lasts exactly 1 cycle, because the bubble removes the load dependency from EX on the next edge.
- If `rst` is asserted mid-MEM_WAIT, the FSM returns to INIT, and the counters and `mem_timeout` clear on the next edge.
- If `mem_busy_m` and `lu` are both asserted, the memory freeze wins and the load-use stall resolves after the release.

## Structure
- Package `mips_pipe_pkg`:
  - `hz_state_t` enum {INIT, RUN, MEM_WAIT}.
  - `REG_ZERO` = 5'd0.
  - Default `CNT_W`.
- Sub-module `sat_counter` (parameter W; ports clk, rst, inc, count), instantiated twice for `stall_count` and `flush_count`.
- The wait counter is local, with width `$clog2(MAX_WAIT+1)`.

## Test plan
- **Reset, 1 idle cycle**:
  - During reset and the following cycle: `pc_enable=0` and both flushes = 1.
  - On the next cycle: all enables = 1, `stall_count=1`.
- **Load-use**: `memread_e=1`, `rt_e=8`, `rs_d=8` for 1 cycle.
  - Required: `pc_enable=0`, `ifid_enable=0`, `idex_flush=1`, `exmem_enable=1`, `stall_count` increments by 1.
  - Repeated with `rt_e=0`: no stall.
- **Branch**: `branch_taken_d=1` with no lu.
  - Required: `ifid_flush=1`, `pc_enable=1`, `flush_count` increments by 1.
  - With `branch_taken_d=1` and lu together: stall outputs only, `flush_count` unchanged.
- **Memory busy**: `mem_busy_m=1` for 5 cycles, then 0.
  - Required: all enables 0 for those 5 cycles, `stall_count` increments by 5, full advance on release.
- **Timeout**: with `MAX_WAIT=4`, hold `mem_busy_m=1` for 10 cycles.
  - Required: `mem_timeout=1` from the edge after the 4th wait cycle; it stays 1 after release and until `rst`.
- **Saturation and reset**: with `CNT_W=4`, 20 branches.
  - Required: `flush_count=15`.
  - Asserting `rst` during MEM_WAIT gives state INIT and clears the counters and `mem_timeout`.
